// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: holds the fetch PC, issues one instruction-bus
// request at a time, and delivers one or two instructions per response to
// decode. Redirects drop in-flight responses; decode stalls park the returned
// doubleword in a one-entry hold buffer.
//
// Handshakes: the bus accepts a request in any cycle where inst_req and
// inst_addr_ok are both high; a response is valid only in a cycle where
// inst_data_ok is high. Decode accepts delivered slots only in a cycle where
// id_stall is low, and nothing is delivered in a cycle where redirect is high.
module ifu_fetch_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        id_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic [31:0] pc,
    output logic        inst_rdata_1_ok,
    output logic        inst_rdata_2_ok,
    output logic [31:0] inst_1,
    output logic [31:0] inst_2,
    output logic [31:0] inst_pc_1,
    output logic [31:0] inst_pc_2,
    output logic        fetch_adel,
    output logic [1:0]  fsm_state
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [63:0] hold_data;
    logic        hold_two;

    logic        misaligned;
    logic        deliver_resp;
    logic        deliver_hold;
    logic        deliver_adel;

    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign deliver_resp = (state == S_RESP) && inst_data_ok && !redirect && !id_stall;
    assign deliver_hold = (state == S_HOLD) && !redirect && !id_stall;
    assign deliver_adel = (state == S_REQ) && misaligned && !redirect && !id_stall;

    assign pc        = pc_q;
    assign inst_addr = pc_q;
    assign inst_pc_1 = pc_q;
    assign inst_pc_2 = pc_q + 32'd4;
    assign fsm_state = state;

    // PC follows the next-PC selector every cycle; hold/advance/redirect are its job.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    // Request/response FSM with the one-entry hold buffer for stalled responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_REQ;
            hold_data <= 64'd0;
            hold_two  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    // data_ok is deliberately ignored here so a response left
                    // over from before a reset can never be delivered.
                    if (!misaligned && inst_addr_ok) begin
                        state <= redirect ? S_DROP : S_RESP;
                    end
                end
                S_RESP: begin
                    if (inst_data_ok) begin
                        if (redirect) begin
                            state <= S_REQ;
                        end else if (id_stall) begin
                            hold_data <= inst_rdata;
                            hold_two  <= !pc_q[2];
                            state     <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (redirect) begin
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (redirect || !id_stall) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (inst_data_ok) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Request and delivery outputs decoded from state and this cycle's handshakes.
    always_comb begin
        inst_req        = (state == S_REQ) && !misaligned;
        inst_rdata_1_ok = 1'b0;
        inst_rdata_2_ok = 1'b0;
        inst_1          = 32'd0;
        inst_2          = 32'd0;
        fetch_adel      = 1'b0;
        if (deliver_resp) begin
            inst_rdata_1_ok = 1'b1;
            if (!pc_q[2]) begin
                inst_rdata_2_ok = 1'b1;
                inst_1          = inst_rdata[31:0];
                inst_2          = inst_rdata[63:32];
            end else begin
                inst_1 = inst_rdata[63:32];
            end
        end else if (deliver_hold) begin
            inst_rdata_1_ok = 1'b1;
            if (hold_two) begin
                inst_rdata_2_ok = 1'b1;
                inst_1          = hold_data[31:0];
                inst_2          = hold_data[63:32];
            end else begin
                inst_1 = hold_data[63:32];
            end
        end else if (deliver_adel) begin
            // Misaligned PC: slot 1 carries a zero instruction flagged with fetch_adel.
            inst_rdata_1_ok = 1'b1;
            fetch_adel      = 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed table-driven bench for ifu_fetch_ctrl. Inputs change on the falling
// edge and outputs are compared 1ns later; each table row is one clock cycle.
module tb_ifu_fetch_ctrl;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_RESP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        resetn;
    logic [31:0] next_pc;
    logic        redirect;
    logic        id_stall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic [31:0] pc;
    logic        inst_rdata_1_ok;
    logic        inst_rdata_2_ok;
    logic [31:0] inst_1;
    logic [31:0] inst_2;
    logic [31:0] inst_pc_1;
    logic [31:0] inst_pc_2;
    logic        fetch_adel;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .next_pc         (next_pc),
        .redirect        (redirect),
        .id_stall        (id_stall),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .pc              (pc),
        .inst_rdata_1_ok (inst_rdata_1_ok),
        .inst_rdata_2_ok (inst_rdata_2_ok),
        .inst_1          (inst_1),
        .inst_2          (inst_2),
        .inst_pc_1       (inst_pc_1),
        .inst_pc_2       (inst_pc_2),
        .fetch_adel      (fetch_adel),
        .fsm_state       (fsm_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        redirect;
        logic        stall;
        logic        aok;
        logic        dok;
        logic [63:0] rdata;
        logic [31:0] npc;
        logic [31:0] pc;
        logic        req;
        logic        ok1;
        logic        ok2;
        logic        adel;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic stl, input logic aok, input logic dok,
                                input logic [63:0] rdata, input logic [31:0] npc, input logic [31:0] epc,
                                input logic req, input logic ok1, input logic ok2, input logic adel,
                                input logic [31:0] i1, input logic [31:0] i2, input logic [1:0] st);
        vec_t v;
        v.redirect = rd;  v.stall = stl; v.aok = aok; v.dok = dok;
        v.rdata = rdata;  v.npc = npc;   v.pc = epc;  v.req = req;
        v.ok1 = ok1;      v.ok2 = ok2;   v.adel = adel;
        v.i1 = i1;        v.i2 = i2;     v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic stl, input logic aok, input logic dok,
                         input logic [63:0] rdata, input logic [31:0] npc);
        redirect     = rd;
        id_stall     = stl;
        inst_addr_ok = aok;
        inst_data_ok = dok;
        inst_rdata   = rdata;
        next_pc      = npc;
    endtask

    task automatic check_row(input int row, input vec_t v);
        check("pc",        row, pc,                       v.pc);
        check("inst_addr", row, inst_addr,                v.pc);
        check("inst_req",  row, 32'(inst_req),            32'(v.req));
        check("ok_1",      row, 32'(inst_rdata_1_ok),     32'(v.ok1));
        check("ok_2",      row, 32'(inst_rdata_2_ok),     32'(v.ok2));
        check("fetch_adel",row, 32'(fetch_adel),          32'(v.adel));
        check("inst_1",    row, inst_1,                   v.i1);
        check("inst_2",    row, inst_2,                   v.i2);
        check("inst_pc_1", row, inst_pc_1,                v.pc);
        check("inst_pc_2", row, inst_pc_2,                v.pc + 32'd4);
        check("state",     row, 32'(fsm_state),           32'(v.st));
    endtask

    initial begin
        // Inputs are applied before the row's rising edge; pc column is the PC seen during the row.
        vecs.push_back(mk(0,0,1,0,64'h0,                   RST_PC,        RST_PC,        1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,0,1,64'hAAAA0001_BBBB0000,   32'hBFC00008,  RST_PC,        0,1,1,0,32'hBBBB0000,32'hAAAA0001,S_RESP));
        vecs.push_back(mk(1,0,0,0,64'h0,                   32'hBFC00004,  32'hBFC00008,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,1,0,64'h0,                   32'hBFC00004,  32'hBFC00004,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,0,1,64'h11111111_22222222,   32'hBFC00008,  32'hBFC00004,  0,1,0,0,32'h11111111,32'h0,S_RESP));
        vecs.push_back(mk(0,0,1,0,64'h0,                   32'hBFC00008,  32'hBFC00008,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(1,0,0,0,64'h0,                   32'h80000180,  32'hBFC00008,  0,0,0,0,32'h0,32'h0,S_RESP));
        vecs.push_back(mk(0,0,0,1,64'hDEADBEEF_CAFEF00D,   32'h80000180,  32'h80000180,  0,0,0,0,32'h0,32'h0,S_DROP));
        vecs.push_back(mk(1,0,1,0,64'h0,                   32'h80000200,  32'h80000180,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(1,0,0,0,64'h0,                   32'h80000300,  32'h80000200,  0,0,0,0,32'h0,32'h0,S_DROP));
        vecs.push_back(mk(0,0,0,1,64'h01234567_89ABCDEF,   32'h80000300,  32'h80000300,  0,0,0,0,32'h0,32'h0,S_DROP));
        vecs.push_back(mk(0,0,1,0,64'h0,                   32'h80000300,  32'h80000300,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(1,0,0,1,64'h0BAD0BAD_0BAD0BAD,   32'hBFC00002,  32'h80000300,  0,0,0,0,32'h0,32'h0,S_RESP));
        vecs.push_back(mk(0,0,0,0,64'h0,                   32'hBFC00002,  32'hBFC00002,  0,1,0,1,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,1,0,0,64'h0,                   32'hFFFFFFFC,  32'hBFC00002,  0,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,1,0,64'h0,                   32'hFFFFFFFC,  32'hFFFFFFFC,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,0,1,64'h55555555_66666666,   32'h00000000,  32'hFFFFFFFC,  0,1,0,0,32'h55555555,32'h0,S_RESP));
        vecs.push_back(mk(0,0,1,0,64'h0,                   32'h00000000,  32'h00000000,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,0,0,64'h0,                   32'h00000000,  32'h00000000,  0,0,0,0,32'h0,32'h0,S_RESP));
        vecs.push_back(mk(0,1,0,1,64'h77777777_88888888,   32'h00000000,  32'h00000000,  0,0,0,0,32'h0,32'h0,S_RESP));
        vecs.push_back(mk(0,1,0,0,64'h0,                   32'h00000000,  32'h00000000,  0,0,0,0,32'h0,32'h0,S_HOLD));
        vecs.push_back(mk(0,1,0,0,64'h0,                   32'h00000000,  32'h00000000,  0,0,0,0,32'h0,32'h0,S_HOLD));
        vecs.push_back(mk(0,0,0,0,64'h0,                   32'h00000008,  32'h00000000,  0,1,1,0,32'h88888888,32'h77777777,S_HOLD));
        vecs.push_back(mk(0,0,0,1,64'hEEEEEEEE_EEEEEEEE,   32'h00000008,  32'h00000008,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,0,1,0,64'h0,                   32'h00000008,  32'h00000008,  1,0,0,0,32'h0,32'h0,S_REQ));
        vecs.push_back(mk(0,1,0,1,64'h99999999_AAAAAAAA,   32'h00000008,  32'h00000008,  0,0,0,0,32'h0,32'h0,S_RESP));
        vecs.push_back(mk(1,0,0,0,64'h0,                   RST_PC,        32'h00000008,  0,0,0,0,32'h0,32'h0,S_HOLD));
        vecs.push_back(mk(0,0,0,0,64'h0,                   RST_PC,        RST_PC,        1,0,0,0,32'h0,32'h0,S_REQ));

        // Reset state.
        resetn = 1'b0;
        drive(0, 0, 0, 0, 64'h0, RST_PC);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_pc",    -1, pc,                   RST_PC);
        check("rst_state", -1, 32'(fsm_state),       32'(S_REQ));
        check("rst_ok_1",  -1, 32'(inst_rdata_1_ok), 32'd0);
        check("rst_ok_2",  -1, 32'(inst_rdata_2_ok), 32'd0);
        check("rst_adel",  -1, 32'(fetch_adel),      32'd0);

        // First cycle after release: request to the reset vector.
        resetn = 1'b1;
        #1;
        check("rel_req",  -1, 32'(inst_req), 32'd1);
        check("rel_addr", -1, inst_addr,     RST_PC);

        // Main directed sequence.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].redirect, vecs[i].stall, vecs[i].aok, vecs[i].dok, vecs[i].rdata, vecs[i].npc);
            #1;
            check_row(i, vecs[i]);
        end

        // Reset while a response is outstanding; the late data_ok must be ignored.
        @(negedge clk);
        drive(0, 0, 1, 0, 64'h0, RST_PC);
        @(negedge clk);
        drive(0, 0, 0, 0, 64'h0, 32'h12345678);
        #1;
        check("arst_pre_state", -2, 32'(fsm_state), 32'(S_RESP));
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_pc",    -2, pc,             RST_PC);
        check("arst_state", -2, 32'(fsm_state), 32'(S_REQ));
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 1, 64'hFACEFACE_FACEFACE, RST_PC);
        #1;
        check("late_ok_1", -2, 32'(inst_rdata_1_ok), 32'd0);
        check("late_ok_2", -2, 32'(inst_rdata_2_ok), 32'd0);
        check("late_req",  -2, 32'(inst_req),        32'd1);
        check("late_addr", -2, inst_addr,            RST_PC);
        @(negedge clk);
        drive(0, 0, 0, 0, 64'h0, RST_PC);
        #1;
        check("late_state", -2, 32'(fsm_state), 32'(S_REQ));
        check("late_req2",  -2, 32'(inst_req),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk clocks all state, and resetn low clears state immediately, independent of clk.
REQ-002 clk  in  1  fetch clock, all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 next_pc  in  32  next fetch PC from the next-PC selector.
REQ-005 redirect  in  1  exception, jump, branch or jr taken this cycle (OR of selector control inputs).
REQ-006 id_stall  in  1  decode cannot accept instructions this cycle.
REQ-007 inst_req  out  1  instruction-bus request.
REQ-008 inst_addr  out  32  request address, equal to pc.
REQ-009 inst_addr_ok  in  1  bus accepted the request.
REQ-010 inst_data_ok  in  1  response data valid.
REQ-011 inst_rdata  in  64  doubleword at {inst_addr[31:3],3'b000}; [31:0] is the word at offset 0, [63:32] the word at offset 4.
REQ-012 pc  out  32  current fetch PC, fed back to the selector.
REQ-013 inst_rdata_1_ok / inst_rdata_2_ok  out  1 each  slot 1 / slot 2 delivered to decode this cycle.
REQ-014 inst_1 / inst_2  out  32 each  delivered instructions.
REQ-015 inst_pc_1 / inst_pc_2  out  32 each  PCs of the delivered instructions: pc and pc+4.
REQ-016 fetch_adel  out  1  misaligned fetch (pc[1:0]!=0) delivered in slot 1.

Function
REQ-017 pc SHALL load next_pc on every rising edge; hold, advance and redirect all come from the selector.
REQ-018 The FSM SHALL have states S_REQ, S_RESP, S_HOLD and S_DROP.
REQ-019 S_REQ: inst_req=1 when pc[1:0]==0; inst_addr may change while inst_addr_ok=0.
- addr_ok=1 & redirect=0 -> S_RESP.
- addr_ok=1 & redirect=1 -> S_DROP.
REQ-020 S_REQ with pc[1:0]!=0: inst_req=0; when ~id_stall & ~redirect, drive ok_1=1, fetch_adel=1, inst_1=0, ok_2=0; stay in S_REQ.
REQ-021 S_RESP with data_ok=1:
- redirect -> discard the data, go to S_REQ.
- else id_stall -> capture inst_rdata and the slot count in the hold buffer, go to S_HOLD, ok outputs 0.
- else deliver in the same cycle, go to S_REQ.
REQ-022 S_RESP with data_ok=0 & redirect=1 -> S_DROP.
REQ-023 S_HOLD: deliver from the buffer when ~id_stall & ~redirect, then go to S_REQ; redirect -> discard, go to S_REQ.
REQ-024 S_DROP: inst_req=0 and ok outputs 0; data_ok -> discard, go to S_REQ; a further redirect updates pc and stays in S_DROP.
REQ-025 Slot count on delivery: pc[2]==0 -> ok_1=ok_2=1, inst_1=rdata[31:0], inst_2=rdata[63:32]; pc[2]==1 -> ok_1=1, ok_2=0, inst_1=rdata[63:32].
REQ-026 All ok outputs SHALL be 0 whenever redirect=1, id_stall=1, or no data is being delivered.
REQ-027 At most one request SHALL be outstanding; no new inst_req before the current response has been consumed or dropped.
REQ-028 inst_pc_2 SHALL be pc+4 with 32-bit wrap-around (0xFFFFFFFC -> 0x00000000).

Reset
REQ-029 On resetn low: pc=0xBFC00000, state=S_REQ, hold buffer cleared, all ok outputs and fetch_adel=0.
REQ-030 Reset during S_RESP or S_DROP SHALL return the block to S_REQ; the late data_ok after release SHALL be ignored, because S_REQ does not act on data_ok.
REQ-031 On the first cycle after release, inst_req=1 and inst_addr=0xBFC00000.

Verification
REQ-032 Reset release, addr_ok and data_ok one cycle apart, no stall, pc=0xBFC00000 -> ok_1=ok_2=1, inst_pc_2=0xBFC00004, selector makes pc 0xBFC00008.
REQ-033 pc=0xBFC00004, rdata=0x11111111_22222222 -> ok_1=1, ok_2=0, inst_1=0x11111111.
REQ-034 data_ok with id_stall high for 3 cycles -> ok outputs 0 for 3 cycles, then the buffered pair is delivered once and pc is unchanged until then.
REQ-035 Redirect to 0x80000180 one cycle after addr_ok -> S_DROP, returned data never delivered, next request address 0x80000180.
REQ-036 pc=0xBFC00002 -> inst_req stays 0, fetch_adel=1, ok_1=1, inst_1=0.
REQ-037 resetn low while in S_RESP, data_ok arrives after release -> no ok output, request to 0xBFC00000 issued.
